// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for 16 requesters sharing one muxed WIDTH-bit channel with burst grants.
// Optional stall timeout with forced release is enabled by defining MUX16_ARB_TIMEOUT_EN.
module mux16_rr_arbiter #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           req,
  input  logic [16*WIDTH-1:0]   datain,
  input  logic                  out_ready,
  output logic [3:0]            select,
  output logic [15:0]           grant,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out,
  output logic [15:0]           ack
`ifdef MUX16_ARB_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [3:0]  select_q;
  logic [15:0] grant_q;
  logic [7:0]  count_q;
  logic [3:0]  last_q;
  logic [15:0] ack_q;
  logic [3:0]  winner;
  logic        accept;
  logic        burst_done;

`ifdef MUX16_ARB_TIMEOUT_EN
  logic [7:0]  stall_q;
  logic        timeout_q;
  assign timeout = timeout_q;
`endif

  // First requester after the last owner, wrapping 15 -> 0.
  always_comb begin
    logic       found;
    logic [3:0] idx;
    found  = 1'b0;
    winner = last_q;
    for (int i = 1; i <= 16; i++) begin
      idx = last_q + 4'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    out_valid  = (state_q == StBusy) && req[select_q];
    out        = out_valid ? datain[select_q*WIDTH +: WIDTH] : '0;
    accept     = out_valid && out_ready;
    burst_done = (count_q + 8'd1) == 8'(BURST_LEN);
  end

  assign select = select_q;
  assign grant  = grant_q;
  assign ack    = ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      select_q  <= '0;
      grant_q   <= '0;
      count_q   <= '0;
      last_q    <= 4'hf;
      ack_q     <= '0;
`ifdef MUX16_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef MUX16_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q  <= StBusy;
            select_q <= winner;
            grant_q  <= 16'(1) << winner;
            count_q  <= '0;
`ifdef MUX16_ARB_TIMEOUT_EN
            stall_q  <= '0;
`endif
          end
        end
        StBusy: begin
          if (accept) begin
            ack_q   <= 16'(1) << select_q;
            count_q <= count_q + 8'd1;
`ifdef MUX16_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (burst_done) begin
              state_q <= StIdle;
              last_q  <= select_q;
              grant_q <= '0;
            end
          end else if (!req[select_q]) begin
            state_q <= StIdle;
            last_q  <= select_q;
            grant_q <= '0;
          end
`ifdef MUX16_ARB_TIMEOUT_EN
          else begin
            // Valid but stalled: the pending beat is dropped without ack on expiry.
            if ((stall_q + 8'd1) == 8'(TIMEOUT)) begin
              state_q   <= StIdle;
              last_q    <= select_q;
              grant_q   <= '0;
              timeout_q <= 1'b1;
            end else begin
              stall_q <= stall_q + 8'd1;
            end
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: an integer-level model predicts grants, beats and
// acks; a negedge monitor pops and compares. Define MUX16_ARB_TIMEOUT_EN to cover the timeout.
module tb_mux16_rr_arbiter;
  localparam int unsigned WIDTH     = 6;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned TIMEOUT   = 16;
`ifdef MUX16_ARB_TIMEOUT_EN
  localparam int STALL = 20;
`else
  localparam int STALL = 10;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [15:0]         req = '0;
  logic [16*WIDTH-1:0] datain = '0;
  logic                out_ready = 1'b0;
  logic [3:0]          select;
  logic [15:0]         grant;
  logic                out_valid;
  logic [WIDTH-1:0]    out;
  logic [15:0]         ack;
`ifdef MUX16_ARB_TIMEOUT_EN
  logic                timeout;
`endif

  mux16_rr_arbiter #(
    .WIDTH    (WIDTH),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .datain   (datain),
    .out_ready(out_ready),
    .select   (select),
    .grant    (grant),
    .out_valid(out_valid),
    .out      (out),
    .ack      (ack)
`ifdef MUX16_ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: current owner (-1 idle), beats taken, last owner, stall length.
  int          m_owner = -1;
  int          m_count = 0;
  int          m_last  = 15;
  int          m_stall = 0;
  logic [15:0] exp_grant = '0;
  bit          exp_to = 1'b0;
  int          beat_q[$];
  int          ack_q[$];
  logic [16*WIDTH-1:0] tbl_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] slice(input int s);
    return datain[s*WIDTH +: WIDTH];
  endfunction

  task automatic model_release();
    m_last  = m_owner;
    m_owner = -1;
  endtask

  // Applies the arbitration rules to the inputs present at this clock edge.
  task automatic model_edge();
    bit found;
    exp_to = 1'b0;
    if (m_owner < 0) begin
      if (req != 0) begin
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
          int s;
          s = (m_last + i) % 16;
          if (!found && req[s]) begin
            found   = 1'b1;
            m_owner = s;
          end
        end
        m_count = 0;
        m_stall = 0;
      end
    end else if (req[m_owner] && out_ready) begin
      ack_q.push_back(m_owner);
      m_count++;
      m_stall = 0;
      if (m_count == BURST_LEN) model_release();
    end else if (!req[m_owner]) begin
      model_release();
    end
`ifdef MUX16_ARB_TIMEOUT_EN
    else begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        model_release();
        exp_to = 1'b1;
      end
    end
`endif
    exp_grant = (m_owner < 0) ? 16'h0 : (16'(1) << m_owner);
  endtask

  // One clock: model update at the edge, then drive new inputs and predict the beat.
  // dmode: 0 keep data, 1 randomize non-requesting sources, 2 load tbl_data.
  task automatic cycle(input logic [15:0] r, input bit rdy, input int dmode);
    @(posedge clk);
    model_edge();
    #1;
    req       = r;
    out_ready = rdy;
    if (dmode == 2) datain = tbl_data;
    else if (dmode == 1) begin
      for (int s = 0; s < 16; s++)
        if (!r[s]) datain[s*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    if (m_owner >= 0 && req[m_owner] && out_ready) beat_q.push_back(m_owner);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    beat_q.delete();
    ack_q.delete();
    m_owner   = -1;
    m_last    = 15;
    m_count   = 0;
    m_stall   = 0;
    exp_grant = '0;
    exp_to    = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_select", select, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ack", ack, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] ea;
    logic        ev;
    bit          bp;
    int          src;
    if (rst_n) begin
      chk("grant", grant, exp_grant);
      if (m_owner >= 0) chk("select", select, m_owner);
      ev = (m_owner >= 0) && req[m_owner];
      chk("out_valid", out_valid, ev);
      chk("out", out, ev ? slice(m_owner) : '0);
      bp = beat_q.size() > 0;
      chk("beat", out_valid && out_ready, bp);
      if (bp) begin
        src = beat_q.pop_front();
        chk("beat_src", select, src);
      end
      ea = '0;
      if (ack_q.size() > 0) ea = 16'(1) << ack_q.pop_front();
      chk("ack", ack, ea);
`ifdef MUX16_ARB_TIMEOUT_EN
      chk("timeout", timeout, exp_to);
`endif
    end
  end

  initial begin
    int tbl[16] = '{20, 15, 25, 10, 5, 17, 8, 16, 30, 1, 32, 50, 7, 11, 23, 14};
    #2;
    chk("init_grant", grant, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_ack", ack, 0);
    do_reset();

    // Single requester: 1-cycle grant latency, 4-beat burst, bubble, re-grant.
    tbl_data = '0;
    tbl_data[0 +: WIDTH] = WIDTH'(20);
    cycle(16'h0001, 1'b1, 2);
    cycle(16'h0001, 1'b1, 0);
    chk("first_grant", grant, 16'h0001);
    chk("first_select", select, 0);
    chk("first_out", out, 20);
    chk("first_valid", out_valid, 1);
    repeat (12) cycle(16'h0001, 1'b1, 0);

    // All sources requesting with the data table.
    for (int i = 0; i < 16; i++) tbl_data[i*WIDTH +: WIDTH] = WIDTH'(tbl[i]);
    cycle(16'hffff, 1'b1, 2);
    repeat (90) cycle(16'hffff, 1'b1, 0);
    repeat (3) cycle(16'h0000, 1'b1, 0);

    // Source 3 drops after two beats; source 5 must follow.
    cycle(16'h0008, 1'b1, 0);
    cycle(16'h0028, 1'b1, 0);
    cycle(16'h0028, 1'b1, 0);
    cycle(16'h0020, 1'b1, 0);
    cycle(16'h0020, 1'b1, 0);
    cycle(16'h0020, 1'b1, 0);
    chk("after3_grant", grant, 16'h0020);
    repeat (6) cycle(16'h0000, 1'b1, 0);

    // Wrap: source 0 first, then 15.
    do_reset();
    cycle(16'h8001, 1'b1, 1);
    repeat (14) cycle(16'h8001, 1'b1, 0);
    repeat (3) cycle(16'h0000, 1'b1, 0);

    // Consumer stall mid-burst.
    cycle(16'h0004, 1'b1, 1);
    cycle(16'h0004, 1'b1, 0);
    repeat (STALL) cycle(16'h0004, 1'b0, 0);
    repeat (8) cycle(16'h0004, 1'b1, 0);
    repeat (3) cycle(16'h0000, 1'b1, 0);

    // Reset mid-burst on source 7, then it is granted on the first arbitration.
    cycle(16'h0080, 1'b1, 1);
    cycle(16'h0080, 1'b1, 0);
    cycle(16'h0080, 1'b1, 0);
    do_reset();
    cycle(16'h0080, 1'b1, 0);
    cycle(16'h0080, 1'b1, 0);
    chk("post_rst_grant", grant, 16'h0080);
    repeat (4) cycle(16'h0000, 1'b1, 0);

    // Randomized traffic.
    repeat (600) cycle(16'($urandom & $urandom), $urandom_range(0, 3) != 0, 1);
    repeat (4) cycle(16'h0000, 1'b1, 0);
    chk("beats_drained", beat_q.size(), 0);
    chk("acks_drained", ack_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
